// File: rtl/dt_pkg.sv
// Shared DT definitions: image geometry, RAM widths and the scan FSM encoding.
package dt_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned N_PIX  = IMG_W * IMG_W;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned THRESH = 4;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned SUM_W  = 22;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } dt_state_e;

endpackage

// File: rtl/dt_result_stats_if.sv
// Result-RAM read port shared between the DT engine and the statistics scanner.
interface dt_result_stats_if;
  import dt_pkg::*;

  logic              res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di;

  modport master (output res_rd, output res_addr, input res_di);
  modport slave  (input res_rd, input res_addr, output res_di);

endinterface

// File: rtl/dt_stat_accum.sv
// Folds one distance sample per cycle into max/location/count/sum/ridge accumulators.
module dt_stat_accum
  import dt_pkg::*;
#(
  parameter int unsigned THRESH_P = THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              smp_vld,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [ADDR_W-1:0] smp_addr,
  output logic [DATA_W-1:0] max_dist,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  obj_cnt,
  output logic [SUM_W-1:0]  dist_sum,
  output logic [CNT_W-1:0]  ridge_cnt
);

  logic [DATA_W-1:0] max_dist_q, max_dist_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic [CNT_W-1:0]  obj_cnt_q, obj_cnt_d;
  logic [SUM_W-1:0]  dist_sum_q, dist_sum_d;
  logic [CNT_W-1:0]  ridge_cnt_q, ridge_cnt_d;

  always_comb begin
    max_dist_d  = max_dist_q;
    max_addr_d  = max_addr_q;
    obj_cnt_d   = obj_cnt_q;
    dist_sum_d  = dist_sum_q;
    ridge_cnt_d = ridge_cnt_q;
    if (clear) begin
      max_dist_d  = '0;
      max_addr_d  = '0;
      obj_cnt_d   = '0;
      dist_sum_d  = '0;
      ridge_cnt_d = '0;
    end else if (smp_vld) begin
      // Strict compare so ties keep the lowest (earliest scanned) address.
      if (smp_data > max_dist_q) begin
        max_dist_d = smp_data;
        max_addr_d = smp_addr;
      end
      obj_cnt_d   = obj_cnt_q + CNT_W'(smp_data != '0);
      ridge_cnt_d = ridge_cnt_q + CNT_W'(smp_data >= DATA_W'(THRESH_P));
      dist_sum_d  = dist_sum_q + SUM_W'(smp_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_dist_q  <= '0;
      max_addr_q  <= '0;
      obj_cnt_q   <= '0;
      dist_sum_q  <= '0;
      ridge_cnt_q <= '0;
    end else begin
      max_dist_q  <= max_dist_d;
      max_addr_q  <= max_addr_d;
      obj_cnt_q   <= obj_cnt_d;
      dist_sum_q  <= dist_sum_d;
      ridge_cnt_q <= ridge_cnt_d;
    end
  end

  assign max_dist  = max_dist_q;
  assign max_addr  = max_addr_q;
  assign obj_cnt   = obj_cnt_q;
  assign dist_sum  = dist_sum_q;
  assign ridge_cnt = ridge_cnt_q;

endmodule

// File: rtl/dt_result_stats.sv
// Raster-scans the DT result RAM once per start pulse and reports distance statistics.
module dt_result_stats
  import dt_pkg::*;
#(
  parameter int unsigned THRESH_P = THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  dt_result_stats_if.master ram,
  output logic              busy,
  output logic              stat_valid,
  output logic [DATA_W-1:0] max_dist,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  obj_cnt,
  output logic [SUM_W-1:0]  dist_sum,
  output logic [CNT_W-1:0]  ridge_cnt
);

  dt_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] smp_q;
  logic [ADDR_W-1:0] smp_addr_q;
  logic              smp_vld_q;
  logic              accept;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (addr_q == LAST_ADDR) state_d = StDrain;
      // Leave only once the final captured sample has been folded.
      StDrain: if (!smp_vld_q) state_d = StDone;
      StDone:  if (start) state_d = StScan;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram.res_rd = (state_q == StScan);
    busy       = (state_q == StScan) || (state_q == StDrain);
    stat_valid = (state_q == StDone);
  end

  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      addr_d = '0;
    end else if ((state_q == StScan) && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Read data for the address held during a SCAN cycle is captured on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      smp_q      <= '0;
      smp_addr_q <= '0;
      smp_vld_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      smp_q      <= ram.res_di;
      smp_addr_q <= addr_q;
      smp_vld_q  <= (state_q == StScan);
    end
  end

  assign ram.res_addr = addr_q;

  dt_stat_accum #(
    .THRESH_P (THRESH_P)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .smp_vld   (smp_vld_q),
    .smp_data  (smp_q),
    .smp_addr  (smp_addr_q),
    .max_dist  (max_dist),
    .max_addr  (max_addr),
    .obj_cnt   (obj_cnt),
    .dist_sum  (dist_sum),
    .ridge_cnt (ridge_cnt)
  );

endmodule

// File: tb/tb_dt_result_stats.sv
// Directed bench for dt_result_stats: negedge-read RAM model and hand-computed statistics.
module tb_dt_result_stats;
  import dt_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              stat_valid;
  logic [DATA_W-1:0] max_dist;
  logic [ADDR_W-1:0] max_addr;
  logic [CNT_W-1:0]  obj_cnt;
  logic [SUM_W-1:0]  dist_sum;
  logic [CNT_W-1:0]  ridge_cnt;

  logic [DATA_W-1:0] mem [N_PIX];

  int vecs;
  int errs;

  dt_result_stats_if ram ();

  dt_result_stats dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ram        (ram),
    .busy       (busy),
    .stat_valid (stat_valid),
    .max_dist   (max_dist),
    .max_addr   (max_addr),
    .obj_cnt    (obj_cnt),
    .dist_sum   (dist_sum),
    .ridge_cnt  (ridge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram.res_rd) ram.res_di <= mem[ram.res_addr];
  end

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int i = 0; i < int'(N_PIX); i++) mem[i] = v;
  endtask

  // Pulses start, then counts edges until stat_valid; optionally re-pulses start mid-scan.
  task automatic launch(input int glitch_at, output int cyc, output logic b0, output logic rd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    b0  = busy;
    rd0 = ram.res_rd;
    cyc = 0;
    while (!stat_valid && cyc < 20000) begin
      start = (cyc == glitch_at);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b0 || stat_valid !== 1'b0 || ram.res_rd !== 1'b0) begin
      errs++; $display("FAIL reset_ctrl got busy=%b sv=%b rd=%b exp 0/0/0", busy, stat_valid, ram.res_rd);
    end
    vecs++; if (max_dist !== '0 || max_addr !== '0 || obj_cnt !== '0 || dist_sum !== '0 || ridge_cnt !== '0) begin
      errs++; $display("FAIL reset_stats got %0d %0d %0d %0d %0d exp all 0", max_dist, max_addr, obj_cnt, dist_sum, ridge_cnt);
    end
    vecs++; if (ram.res_addr !== '0) begin
      errs++; $display("FAIL reset_addr got %0d exp 0", ram.res_addr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero_ignored_start();
    int cyc; logic b0, rd0;
    fill(8'h00);
    launch(200, cyc, b0, rd0);
    vecs++; if (b0 !== 1'b1 || rd0 !== 1'b1) begin
      errs++; $display("FAIL zero_accept got busy=%b rd=%b exp 1/1", b0, rd0);
    end
    vecs++; if (cyc !== 16386) begin
      errs++; $display("FAIL zero_latency got %0d exp 16386", cyc);
    end
    vecs++; if (max_dist !== 8'd0 || max_addr !== 14'd0) begin
      errs++; $display("FAIL zero_max got %0d@%0d exp 0@0", max_dist, max_addr);
    end
    vecs++; if (obj_cnt !== 15'd0 || dist_sum !== 22'd0 || ridge_cnt !== 15'd0) begin
      errs++; $display("FAIL zero_counts got %0d %0d %0d exp 0 0 0", obj_cnt, dist_sum, ridge_cnt);
    end
    vecs++; if (busy !== 1'b0 || ram.res_rd !== 1'b0 || ram.res_addr !== 14'd16383) begin
      errs++; $display("FAIL zero_done got busy=%b rd=%b addr=%0d exp 0 0 16383", busy, ram.res_rd, ram.res_addr);
    end
  endtask

  task automatic test_all_ones();
    int cyc; logic b0, rd0;
    fill(8'h01);
    launch(-1, cyc, b0, rd0);
    vecs++; if (cyc !== 16386) begin
      errs++; $display("FAIL ones_latency got %0d exp 16386", cyc);
    end
    vecs++; if (max_dist !== 8'd1 || max_addr !== 14'd0) begin
      errs++; $display("FAIL ones_max got %0d@%0d exp 1@0", max_dist, max_addr);
    end
    vecs++; if (obj_cnt !== 15'd16384 || dist_sum !== 22'd16384 || ridge_cnt !== 15'd0) begin
      errs++; $display("FAIL ones_counts got %0d %0d %0d exp 16384 16384 0", obj_cnt, dist_sum, ridge_cnt);
    end
    repeat (5) @(posedge clk);
    #1;
    vecs++; if (stat_valid !== 1'b1 || obj_cnt !== 15'd16384) begin
      errs++; $display("FAIL ones_hold got sv=%b obj=%0d exp 1 16384", stat_valid, obj_cnt);
    end
  endtask

  task automatic test_sparse();
    int cyc; logic b0, rd0;
    fill(8'h00);
    mem[5000] = 8'd9;
    mem[9000] = 8'd9;
    mem[100]  = 8'd3;
    launch(-1, cyc, b0, rd0);
    vecs++; if (cyc !== 16386) begin
      errs++; $display("FAIL sparse_latency got %0d exp 16386", cyc);
    end
    vecs++; if (max_dist !== 8'd9 || max_addr !== 14'd5000) begin
      errs++; $display("FAIL sparse_max got %0d@%0d exp 9@5000", max_dist, max_addr);
    end
    vecs++; if (obj_cnt !== 15'd3 || dist_sum !== 22'd21 || ridge_cnt !== 15'd2) begin
      errs++; $display("FAIL sparse_counts got %0d %0d %0d exp 3 21 2", obj_cnt, dist_sum, ridge_cnt);
    end
  endtask

  task automatic test_saturated();
    int cyc; logic b0, rd0;
    fill(8'hFF);
    launch(-1, cyc, b0, rd0);
    vecs++; if (cyc !== 16386) begin
      errs++; $display("FAIL ff_latency got %0d exp 16386", cyc);
    end
    vecs++; if (max_dist !== 8'd255 || max_addr !== 14'd0) begin
      errs++; $display("FAIL ff_max got %0d@%0d exp 255@0", max_dist, max_addr);
    end
    vecs++; if (obj_cnt !== 15'd16384 || dist_sum !== 22'd4177920 || ridge_cnt !== 15'd16384) begin
      errs++; $display("FAIL ff_counts got %0d %0d %0d exp 16384 4177920 16384", obj_cnt, dist_sum, ridge_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc; logic b0, rd0;
    fill(8'hFF);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vecs++; if (ram.res_rd !== 1'b0 || busy !== 1'b0 || stat_valid !== 1'b0) begin
      errs++; $display("FAIL midrst_ctrl got rd=%b busy=%b sv=%b exp 0/0/0", ram.res_rd, busy, stat_valid);
    end
    vecs++; if (max_dist !== '0 || obj_cnt !== '0 || dist_sum !== '0 || ridge_cnt !== '0 || ram.res_addr !== '0) begin
      errs++; $display("FAIL midrst_stats got %0d %0d %0d %0d addr=%0d exp all 0", max_dist, obj_cnt, dist_sum, ridge_cnt, ram.res_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Fresh image after release: only the last pixel is set, so it must be folded in DRAIN.
    fill(8'h00);
    mem[16383] = 8'd200;
    launch(-1, cyc, b0, rd0);
    vecs++; if (cyc !== 16386) begin
      errs++; $display("FAIL last_latency got %0d exp 16386", cyc);
    end
    vecs++; if (max_dist !== 8'd200 || max_addr !== 14'd16383) begin
      errs++; $display("FAIL last_max got %0d@%0d exp 200@16383", max_dist, max_addr);
    end
    vecs++; if (obj_cnt !== 15'd1 || dist_sum !== 22'd200 || ridge_cnt !== 15'd1) begin
      errs++; $display("FAIL last_counts got %0d %0d %0d exp 1 200 1", obj_cnt, dist_sum, ridge_cnt);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_zero_ignored_start();
    test_all_ones();
    test_sparse();
    test_saturated();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
